// File: rtl/self_test_result_collector_pkg.sv
// Shared types and width helpers for the self-test result collector.
// State encoding plus derived golden/counter widths.
package self_test_result_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_SIZE     = 8;
    localparam int DEF_WEIGHT_W = 8;
    localparam int DEF_ACT_W    = 8;
    localparam int DEF_PATTERNS = 4;
    localparam int DEF_TIMEOUT  = 64;

    function automatic int psum_width(input int ww, input int aw, input int size);
        return ww + aw + $clog2(size);
    endfunction

    // Index width that never collapses to zero for tiny ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/self_test_result_collector_popcount_tree.sv
// Combinational population count of the fault map.
// Sized so the all-ones input still fits in the count.
module popcount_tree #(
    parameter int N = 64,
    parameter int W = 7
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(bits[i]);
        end
    end

endmodule

// File: rtl/self_test_result_collector.sv
// Sequences one self-test pass: paces the golden ROM, folds column
// mismatches into a row x column fault map and guards with a watchdog.
module self_test_result_collector
    import self_test_result_collector_pkg::*;
#(
    parameter int SYSTOLIC_SIZE     = DEF_SIZE,
    parameter int WEIGHT_WIDTH      = DEF_WEIGHT_W,
    parameter int ACTIVATION_WIDTH  = DEF_ACT_W,
    parameter int PARTIAL_SUM_WIDTH =
        psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, SYSTOLIC_SIZE),
    parameter int NUM_PATTERNS      = DEF_PATTERNS,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT,
    localparam int ADDR_W  = idx_width(NUM_PATTERNS * SYSTOLIC_SIZE),
    localparam int CELLS   = SYSTOLIC_SIZE * SYSTOLIC_SIZE,
    localparam int COUNT_W = count_width(CELLS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         psum_valid,
    input  logic [SYSTOLIC_SIZE-1:0]     cmp_mismatch,
    output logic [ADDR_W-1:0]            golden_addr,
    input  logic [PARTIAL_SUM_WIDTH-1:0] golden_data,
    output logic [PARTIAL_SUM_WIDTH-1:0] correct_answer,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout,
    output logic [CELLS-1:0]             fault_map_flat,
    output logic [SYSTOLIC_SIZE-1:0]     faulty_col_mask,
    output logic [COUNT_W-1:0]           fault_count
);

    localparam int ROW_W = idx_width(SYSTOLIC_SIZE);
    localparam int PAT_W = idx_width(NUM_PATTERNS);
    localparam int WD_W  = idx_width(TIMEOUT_CYCLES);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SYSTOLIC_SIZE - 1);
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    state_t                                       state;
    logic [ROW_W-1:0]                             row;
    logic [PAT_W-1:0]                             pattern;
    logic [WD_W-1:0]                              watchdog;
    logic [SYSTOLIC_SIZE-1:0][SYSTOLIC_SIZE-1:0]  fault_map;
    logic [SYSTOLIC_SIZE-1:0][SYSTOLIC_SIZE-1:0]  map_next;
    logic [COUNT_W-1:0]                           pop_next;
    logic                                         beat;
    logic                                         last_beat;
    logic                                         expire;

    assign correct_answer = golden_data;
    assign fault_map_flat = fault_map;

    assign beat      = (state == ST_RUN) && psum_valid;
    assign last_beat = beat && (row == ROW_LAST) && (pattern == PAT_LAST);
    assign expire    = (state == ST_RUN) && !psum_valid && (watchdog == WD_LAST);

    always_comb begin
        map_next = fault_map;
        if (beat) begin
            map_next[row] = fault_map[row] | cmp_mismatch;
        end
    end

    always_comb begin
        faulty_col_mask = '0;
        for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
            faulty_col_mask = faulty_col_mask | fault_map[r];
        end
    end

    // Count the map as it will be after this edge so it is ready with done.
    popcount_tree #(
        .N(CELLS),
        .W(COUNT_W)
    ) u_popcount (
        .bits (map_next),
        .count(pop_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            row         <= '0;
            pattern     <= '0;
            watchdog    <= '0;
            golden_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            fault_map   <= '0;
            fault_count <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_RUN;
                        busy        <= 1'b1;
                        row         <= '0;
                        pattern     <= '0;
                        watchdog    <= '0;
                        golden_addr <= '0;
                        timeout     <= 1'b0;
                        fault_map   <= '0;
                        fault_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (psum_valid) begin
                        fault_map <= map_next;
                        watchdog  <= '0;
                        if (last_beat) begin
                            state       <= ST_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            fault_count <= pop_next;
                        end else begin
                            golden_addr <= golden_addr + 1'b1;
                            if (row == ROW_LAST) begin
                                row     <= '0;
                                pattern <= pattern + 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end
                    end else if (expire) begin
                        state       <= ST_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        timeout     <= 1'b1;
                        fault_count <= pop_next;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_self_test_result_collector.sv
// Bench for the self-test result collector: beat-level reference model
// compared every cycle, plus literal expectations per scenario.
module tb_self_test_result_collector;

    logic        clk;
    logic        rst;
    logic        start;
    logic        psum_valid;
    logic [7:0]  cmp_mismatch;
    logic [4:0]  golden_addr;
    logic [18:0] golden_data;
    logic [18:0] correct_answer;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [63:0] fault_map_flat;
    logic [7:0]  faulty_col_mask;
    logic [6:0]  fault_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_done  = 0;
    int start_cyc = 0;
    int done_cyc  = 0;

    // Reference model state: pass phase, beats taken, idle streak, rows.
    int         m_phase = 0;
    int         m_beats = 0;
    int         m_idle  = 0;
    logic [7:0] m_rows[8];
    logic       m_to    = 1'b0;
    logic       m_done  = 1'b0;
    int         m_count = 0;

    function automatic logic [18:0] rom(input int a);
        return 19'(a * 4099 + 13);
    endfunction

    assign golden_data = rom(int'(golden_addr));

    self_test_result_collector dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .psum_valid     (psum_valid),
        .cmp_mismatch   (cmp_mismatch),
        .golden_addr    (golden_addr),
        .golden_data    (golden_data),
        .correct_answer (correct_answer),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .fault_map_flat (fault_map_flat),
        .faulty_col_mask(faulty_col_mask),
        .fault_count    (fault_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int model_pop();
        int c = 0;
        for (int r = 0; r < 8; r++)
            for (int b = 0; b < 8; b++)
                c += int'(m_rows[r][b]);
        return c;
    endfunction

    function automatic logic [63:0] model_flat();
        logic [63:0] f = '0;
        for (int r = 0; r < 8; r++) f[r*8 +: 8] = m_rows[r];
        return f;
    endfunction

    function automatic logic [7:0] model_mask();
        logic [7:0] m = '0;
        for (int r = 0; r < 8; r++) m |= m_rows[r];
        return m;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 8; r++) m_rows[r] = 8'h00;
        m_beats = 0;
        m_idle  = 0;
        m_to    = 1'b0;
        m_count = 0;
    endtask

    // Model: phase 0 idle, 1 running, 2 reporting.
    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_clear();
                m_phase = 0;
                m_done  = 1'b0;
            end else begin
                m_done = 1'b0;
                if (m_phase == 0) begin
                    if (start) begin
                        model_clear();
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (psum_valid) begin
                        m_rows[m_beats % 8] |= cmp_mismatch;
                        m_beats++;
                        m_idle = 0;
                        if (m_beats == 32) begin
                            m_phase = 2;
                            m_done  = 1'b1;
                            m_count = model_pop();
                        end
                    end else begin
                        m_idle++;
                        if (m_idle == 64) begin
                            m_phase = 2;
                            m_done  = 1'b1;
                            m_to    = 1'b1;
                            m_count = model_pop();
                        end
                    end
                end else begin
                    m_phase = 0;
                end
            end
        end
    end

    initial forever begin
        int exp_addr;
        @(negedge clk);
        exp_addr = (m_beats > 31) ? 31 : m_beats;
        check("busy", 64'(busy), 64'(m_phase == 1));
        check("done", 64'(done), 64'(m_done));
        check("timeout", 64'(timeout), 64'(m_to));
        check("map", fault_map_flat, model_flat());
        check("mask", 64'(faulty_col_mask), 64'(model_mask()));
        check("count", 64'(fault_count), 64'(m_count));
        check("addr", 64'(golden_addr), 64'(exp_addr));
        check("answer", 64'(correct_answer), 64'(rom(exp_addr)));
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    function automatic logic [7:0] vec(input int mode, input int k);
        case (mode)
            1:       return (k % 8 == 2) ? 8'h20 : 8'h00;
            2:       return 8'h81;
            3:       return 8'(k + 1);
            4:       return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    task automatic do_start();
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beats(input int mode, input int n, input int gap,
                         input int start_at);
        for (int k = 0; k < n; k++) begin
            psum_valid   = 1'b1;
            cmp_mismatch = vec(mode, k);
            start        = (k == start_at);
            @(negedge clk);
            psum_valid   = 1'b0;
            cmp_mismatch = 8'h00;
            start        = 1'b0;
            if (k < n - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int n0, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(posedge clk);
            if (n_done > n0) break;
        end
        if (i == bound) begin
            n_fail++;
            n_tests++;
            $display("FAIL wait_done: no done within %0d cycles", bound);
        end
        @(negedge clk);
    endtask

    initial begin
        int n0;
        rst          = 1'b1;
        start        = 1'b0;
        psum_valid   = 1'b0;
        cmp_mismatch = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_map", fault_map_flat, 64'd0);
        check("rst_count", 64'(fault_count), 64'd0);
        check("rst_addr", 64'(golden_addr), 64'd0);
        #2 rst = 1'b0;

        n0 = n_done;
        do_start();
        beats(0, 32, 0, -1);
        wait_done(n0, 10);
        check("ff_cycles", 64'(done_cyc - start_cyc + 1), 64'd34);
        check("ff_map", fault_map_flat, 64'd0);
        check("ff_count", 64'(fault_count), 64'd0);
        check("ff_timeout", 64'(timeout), 64'd0);

        n0 = n_done;
        do_start();
        beats(1, 32, 0, -1);
        wait_done(n0, 10);
        check("stuck_map", fault_map_flat, 64'h0000_0000_0020_0000);
        check("stuck_mask", 64'(faulty_col_mask), 64'h20);
        check("stuck_count", 64'(fault_count), 64'd1);

        n0 = n_done;
        do_start();
        beats(2, 32, 0, -1);
        wait_done(n0, 10);
        check("col_map", fault_map_flat, 64'h8181_8181_8181_8181);
        check("col_mask", 64'(faulty_col_mask), 64'h81);
        check("col_count", 64'(fault_count), 64'd16);

        n0 = n_done;
        do_start();
        beats(1, 32, 3, -1);
        wait_done(n0, 10);
        check("gap_map", fault_map_flat, 64'h0000_0000_0020_0000);
        check("gap_count", 64'(fault_count), 64'd1);
        check("gap_timeout", 64'(timeout), 64'd0);

        n0 = n_done;
        do_start();
        beats(3, 10, 0, -1);
        wait_done(n0, 100);
        check("stall_cycles", 64'(done_cyc - start_cyc + 1), 64'd76);
        check("stall_timeout", 64'(timeout), 64'd1);
        check("stall_map", fault_map_flat, 64'h0807_0605_0403_0A09);
        check("stall_mask", 64'(faulty_col_mask), 64'h0F);
        check("stall_count", 64'(fault_count), 64'd15);

        n0 = n_done;
        do_start();
        beats(4, 15, 0, -1);
        psum_valid   = 1'b1;
        cmp_mismatch = 8'hFF;
        #2 rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_map", fault_map_flat, 64'd0);
        check("abort_count", 64'(fault_count), 64'd0);
        check("abort_addr", 64'(golden_addr), 64'd0);
        psum_valid   = 1'b0;
        cmp_mismatch = 8'h00;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(n_done), 64'(n0));

        n0 = n_done;
        do_start();
        beats(1, 32, 0, 5);
        wait_done(n0, 10);
        check("again_cycles", 64'(done_cyc - start_cyc + 1), 64'd34);
        check("again_map", fault_map_flat, 64'h0000_0000_0020_0000);
        check("again_count", 64'(fault_count), 64'd1);
        check("again_ndone", 64'(n_done - n0), 64'd1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_bound: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

endmodule
